// File: rtl/kernel_result_writer.sv
// kernel_result_writer: clamps kernel results into the interior of a result RAM frame and fills
// the one-pixel border in idle write-port cycles.
module kernel_result_writer #(
   parameter int IMG_W      = 256,
   parameter int IMG_H      = 256,
   parameter int ADDR_W     = 16,
   parameter int RES_W      = 17,
   parameter int PIX_W      = 8,
   parameter int BORDER_VAL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              result_valid,
   input  logic [RES_W-1:0]  result_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic              err_overrun
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = ADDR_W - XW;
   localparam int NB = 2 * IMG_W + 2 * (IMG_H - 2);
   localparam int BW = $clog2(NB + 1);
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
   state_t            state_q, state_d;
   logic [XW-1:0]     ix_q, ix_d;
   logic [YW-1:0]     iy_q, iy_d;
   logic [BW-1:0]     bidx_q, bidx_d, k;
   logic              wr_en_q, wr_en_d, err_q, err_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, b_addr;
   logic [PIX_W-1:0]  wr_data_q, wr_data_d, pix;
   logic              int_done, bdr_done;
   always_comb begin
      int_done  = iy_q == YW'(IMG_H - 1);
      bdr_done  = bidx_q == BW'(NB);
      pix       = result_data[RES_W-1] ? '0 : |result_data[RES_W-2:PIX_W] ? '1 : result_data[PIX_W-1:0];
      // side columns are visited in (left, right) pairs per row after both full rows
      k         = bidx_q - BW'(2 * IMG_W);
      b_addr    = bidx_q < BW'(IMG_W) ? ADDR_W'(bidx_q)
                : bidx_q < BW'(2 * IMG_W) ? {YW'(IMG_H - 1), bidx_q[XW-1:0]}
                : {YW'(k >> 1) + YW'(1), k[0] ? XW'(IMG_W - 1) : XW'(0)};
      state_d   = state_q;
      ix_d      = ix_q;
      iy_d      = iy_q;
      bidx_d    = bidx_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      if (state_q != ACTIVE) begin
         if (start) begin
            state_d = ACTIVE;
            ix_d    = XW'(1);
            iy_d    = YW'(1);
            bidx_d  = '0;
            err_d   = 1'b0;
         end else if (result_valid) begin
            err_d = 1'b1;
         end
      end else begin
         if (result_valid) begin
            if (int_done) begin
               err_d = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = {iy_q, ix_q};
               wr_data_d = pix;
               ix_d      = ix_q == XW'(IMG_W - 2) ? XW'(1) : ix_q + XW'(1);
               iy_d      = ix_q == XW'(IMG_W - 2) ? iy_q + YW'(1) : iy_q;
            end
         end else if (!bdr_done) begin
            wr_en_d   = 1'b1;
            wr_addr_d = b_addr;
            wr_data_d = PIX_W'(BORDER_VAL);
            bidx_d    = bidx_q + BW'(1);
         end
         if (int_done && bdr_done) state_d = DONE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ix_q      <= '0;
         iy_q      <= '0;
         bidx_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ix_q      <= ix_d;
         iy_q      <= iy_d;
         bidx_q    <= bidx_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
      end
   end
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = state_q == ACTIVE;
   assign done        = state_q == DONE;
   assign err_overrun = err_q;
endmodule

// File: tb/tb_kernel_result_writer.sv
// tb_kernel_result_writer: randomized checks of kernel_result_writer against a frame-level model
// (expected interior raster order, border order and clamp computed with plain arithmetic).
module tb_kernel_result_writer;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, result_valid = 1'b0;
   logic [16:0] result_data = '0;
   logic        wr_en, busy, done, err_overrun;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   kernel_result_writer dut (
      .clk(clk), .rst(rst), .start(start), .result_valid(result_valid), .result_data(result_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
      .err_overrun(err_overrun)
   );
   always #5 clk = ~clk;
   typedef struct {int addr; int data; int cyc;} wr_t;
   wr_t   wq[$];
   int    border_l[$], interior_l[$];
   logic [16:0] rq[$];
   int    total = 0, bad = 0, cyc_n = 0, done_cyc = -1;
   logic  done_prev = 1'b0;
   int    seen[65536];
   always @(posedge clk) begin
      #1;
      cyc_n++;
      if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), cyc_n});
      if (done && !done_prev) done_cyc = cyc_n;
      done_prev = done;
   end
   function automatic int clampf(logic [16:0] d);
      int v;
      v = int'($signed(d));
      return v < 0 ? 0 : (v > 255 ? 255 : v);
   endfunction
   function automatic bit is_border(int a);
      return a / 256 == 0 || a / 256 == 255 || a % 256 == 0 || a % 256 == 255;
   endfunction
   function automatic wr_t at(int i);
      wr_t w;
      w = '{-1, -1, -1};
      if (i < wq.size()) w = wq[i];
      return w;
   endfunction
   task automatic drive(input logic v, input logic [16:0] d);
      result_valid = v;
      result_data  = d;
      @(negedge clk);
   endtask
   task automatic do_start();
      start = 1'b1;
      drive(1'b0, '0);
      start = 1'b0;
   endtask
   task automatic pulse_reset();
      rst = 1'b1;
      drive(1'b0, '0);
      rst = 1'b0;
      done_cyc = -1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) drive(1'b0, '0);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
      total++; if (wr_addr !== 16'h0) begin bad++; $display("FAIL rst_wr_addr got=%h exp=0000", wr_addr); end
      total++; if (wr_data !== 8'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
      total++; if ({busy, done, err_overrun} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, err_overrun}); end
      rst = 1'b0;
   endtask
   task automatic test_overrun_idle();
      wq.delete();
      drive(1'b1, 17'h00055);
      drive(1'b0, '0);
      total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_idle_err got=%b exp=1", err_overrun); end
      total++; if (wq.size() != 0) begin bad++; $display("FAIL ovr_idle_nowrite got=%0d exp=0", wq.size()); end
   endtask
   task automatic test_clamp();
      logic [16:0] v[3];
      int s;
      v = '{17'h00080, 17'h1FFF0, 17'h00200};
      wq.delete();
      do_start();
      total++; if (err_overrun !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%b exp=0", err_overrun); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b exp=1", busy); end
      s = cyc_n;
      for (int i = 0; i < 3; i++) drive(1'b1, v[i]);
      repeat (3) drive(1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (at(i).addr != interior_l[i] || at(i).data != clampf(v[i]) || at(i).cyc != s + 1 + i) begin
            bad++;
            $display("FAIL clamp_%0d got=%h/%h@%0d exp=%h/%h@%0d", i, at(i).addr, at(i).data, at(i).cyc, interior_l[i], clampf(v[i]), s + 1 + i);
         end
      end
      total++; if (at(3).addr != 0 || at(3).cyc != s + 4) begin bad++; $display("FAIL clamp_border_after got=%h@%0d exp=0000@%0d", at(3).addr, at(3).cyc, s + 4); end
   endtask
   task automatic test_border_only();
      int s, errs;
      pulse_reset();
      wq.delete();
      do_start();
      s = cyc_n;
      repeat (1100) drive(1'b0, '0);
      total++; if (wq.size() != 1020) begin bad++; $display("FAIL border_count got=%0d exp=1020", wq.size()); end
      errs = 0;
      foreach (wq[i]) if (i >= 1020 || wq[i].addr != border_l[i] || wq[i].data != 0 || wq[i].cyc != s + 1 + i) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL border_seq got=%0d bad writes exp=0", errs); end
      total++; if (at(0).addr != 16'h0000 || at(0).cyc != s + 1) begin bad++; $display("FAIL border_w1 got=%h@%0d exp=0000@%0d", at(0).addr, at(0).cyc, s + 1); end
      total++; if (at(256).addr != 16'hFF00) begin bad++; $display("FAIL border_w257 got=%h exp=ff00", at(256).addr); end
      total++; if (at(512).addr != 16'h0100) begin bad++; $display("FAIL border_w513 got=%h exp=0100", at(512).addr); end
      total++; if (at(513).addr != 16'h01FF) begin bad++; $display("FAIL border_w514 got=%h exp=01ff", at(513).addr); end
      total++; if (at(1019).addr != 16'hFEFF) begin bad++; $display("FAIL border_w1020 got=%h exp=feff", at(1019).addr); end
      total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL border_busy_done got=%b exp=10", {busy, done}); end
   endtask
   task automatic test_full_frame();
      int n, ki, kb, errs, dups, miss, last_int;
      logic [16:0] d;
      logic v;
      pulse_reset();
      wq.delete();
      rq.delete();
      do_start();
      n = 0;
      while (rq.size() < 64516 && n < 80000) begin
         v = $urandom_range(0, 31) != 0;
         d = 17'($urandom);
         if (v) rq.push_back(d);
         drive(v, d);
         n++;
      end
      n = 0;
      while (!done && n < 5000) begin drive(1'b0, '0); n++; end
      total++; if (wq.size() != 65536) begin bad++; $display("FAIL ff_count got=%0d exp=65536", wq.size()); end
      for (int i = 0; i < 65536; i++) seen[i] = 0;
      ki = 0; kb = 0; errs = 0; last_int = -1;
      foreach (wq[i]) begin
         seen[wq[i].addr]++;
         if (is_border(wq[i].addr)) begin
            if (kb >= border_l.size() || wq[i].addr != border_l[kb] || wq[i].data != 0) errs++;
            kb++;
         end else begin
            if (ki >= rq.size() || wq[i].addr != interior_l[ki] || wq[i].data != clampf(rq[ki])) errs++;
            ki++;
            last_int = wq[i].addr;
         end
      end
      dups = 0; miss = 0;
      for (int i = 0; i < 65536; i++) begin if (seen[i] > 1) dups++; if (seen[i] == 0) miss++; end
      total++; if (errs != 0) begin bad++; $display("FAIL ff_order got=%0d bad writes exp=0", errs); end
      total++; if (dups != 0 || miss != 0) begin bad++; $display("FAIL ff_once got dup=%0d miss=%0d exp 0/0", dups, miss); end
      total++; if (last_int != 16'hFEFE) begin bad++; $display("FAIL ff_last_int got=%h exp=fefe", last_int); end
      total++; if (wq.size() == 0 || done_cyc != wq[wq.size()-1].cyc + 1) begin bad++; $display("FAIL ff_done_time got=%0d exp=last_write+1", done_cyc); end
      total++; if ({busy, done, err_overrun} !== 3'b010) begin bad++; $display("FAIL ff_flags got=%b exp=010", {busy, done, err_overrun}); end
   endtask
   task automatic test_overrun_late();
      wq.delete();
      drive(1'b1, 17'h00011);
      drive(1'b0, '0);
      total++; if (err_overrun !== 1'b1) begin bad++; $display("FAIL ovr_late_err got=%b exp=1", err_overrun); end
      total++; if (wq.size() != 0) begin bad++; $display("FAIL ovr_late_nowrite got=%0d exp=0", wq.size()); end
      do_start();
      total++; if ({err_overrun, done} !== 2'b00) begin bad++; $display("FAIL ovr_clear got=%b exp=00", {err_overrun, done}); end
   endtask
   task automatic test_back_to_back();
      int s, errs;
      logic [16:0] d;
      pulse_reset();
      wq.delete();
      rq.delete();
      do_start();
      s = cyc_n;
      repeat (300) begin d = 17'($urandom); rq.push_back(d); drive(1'b1, d); end
      repeat (3) drive(1'b0, '0);
      errs = 0;
      for (int i = 0; i < 300; i++)
         if (at(i).addr != interior_l[i] || at(i).data != clampf(rq[i]) || at(i).cyc != s + 1 + i) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL b2b_interior got=%0d bad writes exp=0", errs); end
      total++; if (at(255).addr != 16'h0202) begin bad++; $display("FAIL b2b_wrap got=%h exp=0202", at(255).addr); end
      total++; if (at(300).addr != 16'h0000 || at(300).cyc != s + 301) begin bad++; $display("FAIL b2b_border_resume got=%h@%0d exp=0000@%0d", at(300).addr, at(300).cyc, s + 301); end
   endtask
   task automatic test_reset_mid();
      int n;
      pulse_reset();
      wq.delete();
      do_start();
      n = 0;
      while (wq.size() < 1000 && n < 2000) begin drive(1'b0, '0); n++; end
      rst = 1'b1;
      drive(1'b0, '0);
      total++; if ({wr_en, busy, done} !== 3'b000) begin bad++; $display("FAIL rmid_flags got=%b exp=000", {wr_en, busy, done}); end
      total++; if (wq.size() != 1000) begin bad++; $display("FAIL rmid_count got=%0d exp=1000", wq.size()); end
      rst = 1'b0;
      wq.delete();
      drive(1'b0, '0);
      do_start();
      drive(1'b1, 17'h00042);
      repeat (2) drive(1'b0, '0);
      total++; if (at(0).addr != 16'h0101 || at(0).data != 8'h42) begin bad++; $display("FAIL rmid_int got=%h/%h exp=0101/42", at(0).addr, at(0).data); end
      total++; if (at(1).addr != 16'h0000) begin bad++; $display("FAIL rmid_border got=%h exp=0000", at(1).addr); end
   endtask
   initial begin
      for (int x = 0; x < 256; x++) border_l.push_back(x);
      for (int x = 0; x < 256; x++) border_l.push_back(255 * 256 + x);
      for (int y = 1; y < 255; y++) begin border_l.push_back(y * 256); border_l.push_back(y * 256 + 255); end
      for (int y = 1; y < 255; y++) for (int x = 1; x < 255; x++) interior_l.push_back(y * 256 + x);
      @(negedge clk);
      test_reset();
      test_overrun_idle();
      test_clamp();
      test_border_only();
      test_full_frame();
      test_overrun_late();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
